// File: rtl/mem_dump_pkg.sv
// rtl/mem_dump_pkg.sv - shared state encoding and default widths for the memory dump engine
package mem_dump_pkg;

  localparam int DUMP_DATA_W = 32;
  localparam int DUMP_ADDR_W = 10;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    OUT  = 3'd3,
    FIN  = 3'd4
  } dump_state_t;

endpackage

// File: rtl/mem_dump_engine.sv
// rtl/mem_dump_engine.sv - streams a memory window out over valid/ready, one tagged word at a time
// Optional running checksum port and accumulator: MEM_DUMP_CHECKSUM_EN
module mem_dump_engine
  import mem_dump_pkg::*;
#(
  parameter int DATA_W = DUMP_DATA_W,
  parameter int ADDR_W = DUMP_ADDR_W,
  parameter int CNT_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
`ifdef MEM_DUMP_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data
);

  dump_state_t       state;
  logic [ADDR_W-1:0] cur_addr;
  logic [CNT_W-1:0]  remaining;
  logic [ADDR_W-1:0] next_addr;

  // address arithmetic wraps naturally at 2^ADDR_W
  assign next_addr = cur_addr + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
`ifdef MEM_DUMP_CHECKSUM_EN
      checksum  <= '0;
`endif
    end else begin
      done      <= 1'b0;
      mem_rd_en <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cur_addr  <= base_addr;
            remaining <= count;
            busy      <= 1'b1;
`ifdef MEM_DUMP_CHECKSUM_EN
            checksum  <= '0;
`endif
            if (count == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state     <= RD;
              mem_rd_en <= 1'b1;
              mem_addr  <= base_addr;
            end
          end
        end
        RD: begin
          state <= CAP;
        end
        CAP: begin
          out_data  <= mem_rd_data;
          out_addr  <= cur_addr;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            remaining <= remaining - 1'b1;
            cur_addr  <= next_addr;
`ifdef MEM_DUMP_CHECKSUM_EN
            checksum  <= checksum + out_data;
`endif
            if (remaining == CNT_W'(1)) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              // issue the next read straight away so RD is entered with the strobe up
              state     <= RD;
              mem_rd_en <= 1'b1;
              mem_addr  <= next_addr;
            end
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dump_engine.sv
// tb/tb_mem_dump_engine.sv - directed table-driven bench for mem_dump_engine
module tb_mem_dump_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  base_addr;
  logic [10:0] count;
  logic        busy, done, mem_rd_en;
  logic [9:0]  mem_addr;
  logic [31:0] mem_rd_data;
  logic        out_valid, out_ready;
  logic [9:0]  out_addr;
  logic [31:0] out_data;
`ifdef MEM_DUMP_CHECKSUM_EN
  logic [31:0] checksum;
  logic [31:0] checksum_s;
`endif

  logic        start_s;
  logic [3:0]  base_s;
  logic [4:0]  count_s;
  logic        busy_s, done_s, mem_rd_en_s;
  logic [3:0]  mem_addr_s;
  logic [31:0] mem_rd_data_s;
  logic        out_valid_s, out_ready_s;
  logic [3:0]  out_addr_s;
  logic [31:0] out_data_s;

  logic [31:0] mem   [1024];
  logic [31:0] mem_s [16];

  int cyc = 0;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];
  always @(posedge clk) if (mem_rd_en_s) mem_rd_data_s <= mem_s[mem_addr_s];

  mem_dump_engine #(.DATA_W(32), .ADDR_W(10), .CNT_W(11)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
    .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rd_data(mem_rd_data),
`ifdef MEM_DUMP_CHECKSUM_EN
    .checksum(checksum),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data)
  );

  mem_dump_engine #(.DATA_W(32), .ADDR_W(4), .CNT_W(5)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .base_addr(base_s), .count(count_s),
    .busy(busy_s), .done(done_s), .mem_rd_en(mem_rd_en_s), .mem_addr(mem_addr_s),
    .mem_rd_data(mem_rd_data_s),
`ifdef MEM_DUMP_CHECKSUM_EN
    .checksum(checksum_s),
`endif
    .out_valid(out_valid_s), .out_ready(out_ready_s), .out_addr(out_addr_s), .out_data(out_data_s)
  );

  typedef struct {
    logic [9:0]  base;
    logic [10:0] cnt;
    int          ready_pct;
    int          exp_lat;
    bit          poke;
    bit          has_sum;
    logic [31:0] exp_sum;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_dump(input vec_t v, input int idx);
    int got = 0, rd_cnt = 0, lat = 0, busy_bad = 0, c0;
    bit finished = 0, saw_valid = 0, prev_stall = 0;
    logic [9:0]  pa = '0, ea;
    logic [31:0] pd = '0;
`ifdef MEM_DUMP_CHECKSUM_EN
    logic [31:0] sum_at_done = '0;
`endif
    @(negedge clk);
    base_addr = v.base;
    count     = v.cnt;
    start     = 1'b1;
    out_ready = 1'b0;
    c0 = cyc;
    for (int k = 0; k < 20000 && !finished; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (v.poke && k == 4) begin
        start     = 1'b1;
        base_addr = 10'd0;
        count     = 11'd2;
      end
      if (!busy) busy_bad++;
      if (mem_rd_en) rd_cnt++;
      if (out_valid) saw_valid = 1'b1;
      if (prev_stall)
        check($sformatf("v%0d hold", idx), {out_valid, out_addr, out_data}, {1'b1, pa, pd});
      if (done) begin
        finished = 1'b1;
        lat = cyc - c0 + 1;
`ifdef MEM_DUMP_CHECKSUM_EN
        sum_at_done = checksum;
`endif
      end
      out_ready = ($urandom_range(0, 99) < v.ready_pct);
      if (out_valid && out_ready) begin
        ea = v.base + got[9:0];
        check($sformatf("v%0d w%0d addr", idx, got), 64'(out_addr), 64'(ea));
        check($sformatf("v%0d w%0d data", idx, got), 64'(out_data), 64'(mem[ea]));
        got++;
      end
      prev_stall = out_valid && !out_ready;
      pa = out_addr;
      pd = out_data;
    end
    check($sformatf("v%0d done seen", idx), 64'(finished), 64'd1);
    check($sformatf("v%0d word count", idx), 64'(got), 64'(v.cnt));
    check($sformatf("v%0d rd_en count", idx), 64'(rd_cnt), 64'(v.cnt));
    check($sformatf("v%0d valid seen", idx), 64'(saw_valid), 64'(v.cnt != 0));
    check($sformatf("v%0d busy low cycles", idx), 64'(busy_bad), 64'd0);
    if (v.exp_lat >= 0)
      check($sformatf("v%0d latency", idx), 64'(lat), 64'(v.exp_lat));
`ifdef MEM_DUMP_CHECKSUM_EN
    if (v.has_sum)
      check($sformatf("v%0d checksum", idx), 64'(sum_at_done), 64'(v.exp_sum));
`endif
    @(negedge clk);
    out_ready = 1'b0;
    check($sformatf("v%0d idle after", idx), {busy, done, out_valid}, 3'b000);
  endtask

  initial begin
    logic [3:0] exp_sa [4];
    int n, done_bad, tmo;
    bit fin_s;

    vecs[0] = '{base: 10'd0,    cnt: 11'd50,   ready_pct: 100, exp_lat: 152,  poke: 0, has_sum: 1, exp_sum: 32'hFFFF_FFE7};
    vecs[1] = '{base: 10'd0,    cnt: 11'd0,    ready_pct: 100, exp_lat: 2,    poke: 0, has_sum: 1, exp_sum: 32'h0};
    vecs[2] = '{base: 10'd0,    cnt: 11'd50,   ready_pct: 30,  exp_lat: -1,   poke: 0, has_sum: 1, exp_sum: 32'hFFFF_FFE7};
    vecs[3] = '{base: 10'd1022, cnt: 11'd4,    ready_pct: 100, exp_lat: 14,   poke: 0, has_sum: 0, exp_sum: 32'h0};
    vecs[4] = '{base: 10'd100,  cnt: 11'd5,    ready_pct: 100, exp_lat: 17,   poke: 1, has_sum: 0, exp_sum: 32'h0};
    vecs[5] = '{base: 10'd200,  cnt: 11'd3,    ready_pct: 100, exp_lat: 11,   poke: 0, has_sum: 1, exp_sum: 32'h2};
    vecs[6] = '{base: 10'd1000, cnt: 11'd1030, ready_pct: 100, exp_lat: 3092, poke: 0, has_sum: 0, exp_sum: 32'h0};

    for (int i = 0; i < 1024; i++) mem[i] = 32'(i - 25);
    mem[200] = 32'h1;
    mem[201] = 32'h2;
    mem[202] = 32'hFFFF_FFFF;
    for (int i = 0; i < 16; i++) mem_s[i] = 32'hA0 + 32'(i);

    rst = 1'b0; start = 1'b0; base_addr = '0; count = '0; out_ready = 1'b0;
    start_s = 1'b0; base_s = '0; count_s = '0; out_ready_s = 1'b0;
    repeat (3) @(negedge clk);
    check("reset ctrl", {busy, done, mem_rd_en, out_valid}, 4'b0000);
    check("reset mem_addr", 64'(mem_addr), 64'd0);
    check("reset out_addr", 64'(out_addr), 64'd0);
    check("reset out_data", 64'(out_data), 64'd0);
`ifdef MEM_DUMP_CHECKSUM_EN
    check("reset checksum", 64'(checksum), 64'd0);
`endif
    rst = 1'b1;

    for (int i = 0; i < 7; i++) run_dump(vecs[i], i);

    // small instance: address wrap at 2^4
    exp_sa[0] = 4'd14; exp_sa[1] = 4'd15; exp_sa[2] = 4'd0; exp_sa[3] = 4'd1;
    @(negedge clk);
    base_s = 4'd14; count_s = 5'd4; start_s = 1'b1; out_ready_s = 1'b1;
    n = 0; fin_s = 0;
    for (int k = 0; k < 100 && !fin_s; k++) begin
      @(negedge clk);
      start_s = 1'b0;
      if (out_valid_s && n < 4) begin
        check($sformatf("wrap addr %0d", n), 64'(out_addr_s), 64'(exp_sa[n]));
        check($sformatf("wrap data %0d", n), 64'(out_data_s), 64'(mem_s[exp_sa[n]]));
        n++;
      end
      if (done_s) fin_s = 1'b1;
    end
    check("wrap done", 64'(fin_s), 64'd1);
    check("wrap words", 64'(n), 64'd4);
    @(negedge clk);
    check("wrap idle", {busy_s, done_s}, 2'b00);

    // reset in the middle of a dump
    @(negedge clk);
    base_addr = 10'd300; count = 11'd10; start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tmo = 0;
    while (!out_valid && tmo < 20) begin
      @(negedge clk);
      tmo++;
    end
    check("pre-reset valid", 64'(out_valid), 64'd1);
    rst = 1'b0;
    #1;
    check("abort ctrl", {busy, done, mem_rd_en, out_valid}, 4'b0000);
    check("abort mem_addr", 64'(mem_addr), 64'd0);
    check("abort out_addr", 64'(out_addr), 64'd0);
    check("abort out_data", 64'(out_data), 64'd0);
`ifdef MEM_DUMP_CHECKSUM_EN
    check("abort checksum", 64'(checksum), 64'd0);
`endif
    @(negedge clk);
    rst = 1'b1;
    done_bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done || busy || out_valid || mem_rd_en) done_bad++;
    end
    check("post-abort quiet", 64'(done_bad), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
